// File: rtl/pc_predict_unit.sv
// Fetch PC generator with a direct-mapped branch target buffer.
// Holds the fetch PC, presents PC+4, and predicts the next fetch address
// from a BTB entry (valid, tag, target, 2-bit saturating counter) selected
// by the current PC. Execute feeds back redirects and branch resolutions.
module pc_predict_unit #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    BTB_ENTRIES  = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    input  logic                  upd_en_i,
    input  logic [DATA_WIDTH-1:0] upd_pc_i,
    input  logic [DATA_WIDTH-1:0] upd_target_i,
    input  logic                  upd_taken_i,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] inc_pc_o,
    output logic                  pred_taken_o,
    output logic [DATA_WIDTH-1:0] pred_target_o
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = DATA_WIDTH - IDX_W - 2;

    localparam logic [1:0] CTR_RESET = 2'b01;
    localparam logic [1:0] CTR_ALLOC = 2'b10;
    localparam logic [1:0] CTR_MAX   = 2'b11;
    localparam logic [1:0] CTR_MIN   = 2'b00;

    // Fetch PC
    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] pc_d;
    logic [DATA_WIDTH-1:0] inc_pc;

    // BTB storage
    logic                  valid_q  [BTB_ENTRIES];
    logic [TAG_W-1:0]      tag_q    [BTB_ENTRIES];
    logic [DATA_WIDTH-1:0] target_q [BTB_ENTRIES];
    logic [1:0]            ctr_q    [BTB_ENTRIES];

    // Lookup side (current fetch PC)
    logic [IDX_W-1:0]      lk_idx;
    logic [TAG_W-1:0]      lk_tag;
    logic                  lk_hit;
    logic                  pred_taken;
    logic [DATA_WIDTH-1:0] pred_target;

    // Update side (resolved branch from execute)
    logic [IDX_W-1:0]      upd_idx;
    logic [TAG_W-1:0]      upd_tag;
    logic                  upd_hit;

    // Next contents of the single entry addressed by an update
    logic                  ent_we;
    logic                  ent_valid_d;
    logic [TAG_W-1:0]      ent_tag_d;
    logic [DATA_WIDTH-1:0] ent_target_d;
    logic [1:0]            ent_ctr_d;

    // Word-offset bits of the update PC play no part in index or tag.
    logic                  unused_upd_lsbs;
    assign unused_upd_lsbs = ^upd_pc_i[1:0];

    assign inc_pc  = pc_q + DATA_WIDTH'(4);

    assign lk_idx  = pc_q[IDX_W+1:2];
    assign lk_tag  = pc_q[DATA_WIDTH-1:IDX_W+2];
    assign upd_idx = upd_pc_i[IDX_W+1:2];
    assign upd_tag = upd_pc_i[DATA_WIDTH-1:IDX_W+2];

    // Combinational BTB lookup on the current PC; reads registered contents,
    // so a same-cycle update to this index only shows up next cycle.
    always_comb begin
        lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken  = lk_hit && ctr_q[lk_idx][1];
        pred_target = lk_hit ? target_q[lk_idx] : '0;
    end

    // Tag compare for the entry addressed by the update port.
    always_comb begin
        upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    end

    // Compute the new contents of the updated entry. A hit trains the
    // counter (and refreshes the target when taken); a taken miss evicts
    // whatever lives at that index; a not-taken miss leaves the BTB alone.
    always_comb begin
        ent_we       = 1'b0;
        ent_valid_d  = valid_q[upd_idx];
        ent_tag_d    = tag_q[upd_idx];
        ent_target_d = target_q[upd_idx];
        ent_ctr_d    = ctr_q[upd_idx];
        if (upd_en_i) begin
            if (upd_hit) begin
                ent_we = 1'b1;
                if (upd_taken_i) begin
                    ent_target_d = upd_target_i;
                    if (ctr_q[upd_idx] != CTR_MAX) begin
                        ent_ctr_d = ctr_q[upd_idx] + 2'b01;
                    end
                end else begin
                    if (ctr_q[upd_idx] != CTR_MIN) begin
                        ent_ctr_d = ctr_q[upd_idx] - 2'b01;
                    end
                end
            end else if (upd_taken_i) begin
                ent_we       = 1'b1;
                ent_valid_d  = 1'b1;
                ent_tag_d    = upd_tag;
                ent_target_d = upd_target_i;
                ent_ctr_d    = CTR_ALLOC;
            end
        end
    end

    // Next-PC selection: redirect beats stall, stall beats prediction.
    always_comb begin
        pc_d = inc_pc;
        if (redirect_i) begin
            pc_d = redirect_pc_i;
        end else if (stall_i) begin
            pc_d = pc_q;
        end else if (pred_taken) begin
            pc_d = pred_target;
        end
    end

    // Fetch PC register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    // BTB storage; reset clears every entry and drops any update that cycle.
    // Tags and targets are cleared too so nothing undefined can ever leak out.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_RESET;
            end
        end else if (ent_we) begin
            valid_q[upd_idx]  <= ent_valid_d;
            tag_q[upd_idx]    <= ent_tag_d;
            target_q[upd_idx] <= ent_target_d;
            ctr_q[upd_idx]    <= ent_ctr_d;
        end
    end

    assign pc_o          = pc_q;
    assign inc_pc_o      = inc_pc;
    assign pred_taken_o  = pred_taken;
    assign pred_target_o = pred_target;

endmodule
